// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared widths and types for the register-file writeback path.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int XLEN          = 32;
    localparam int ADDR_SIZE     = 5;
    localparam int NUM_REGISTERS = 32;

    typedef logic [ADDR_SIZE-1:0] reg_addr_t;

    typedef struct packed {
        logic            valid;
        reg_addr_t       addr;
        logic [XLEN-1:0] data;
    } wb_req_t;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_LSU = 1'b1
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Pending-write bit per architectural register with two read ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      i_set_valid,
    input  reg_addr_t i_set_addr,
    input  logic      i_clr_valid,
    input  reg_addr_t i_clr_addr,
    input  reg_addr_t i_query_addr1,
    input  reg_addr_t i_query_addr2,
    output logic      o_busy1,
    output logic      o_busy2
);

    logic [NUM_REGISTERS-1:0] r_pending;
    logic [NUM_REGISTERS-1:0] w_pending_nxt;

    // Set is applied after clear so a same-cycle re-issue keeps the bit.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_clr_valid) begin
            w_pending_nxt[i_clr_addr] = 1'b0;
        end
        if (i_set_valid) begin
            w_pending_nxt[i_set_addr] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign o_busy1 = r_pending[i_query_addr1];
    assign o_busy2 = r_pending[i_query_addr2];

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Round-robin ALU/LSU arbitration onto the register-file write
//                port, registered write stage and RAW scoreboard.
//                Optional forwarding outputs under macro WB_FORWARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_SIZE-1:0] alu_addr,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 lsu_valid,
    output logic                 lsu_ready,
    input  logic [ADDR_SIZE-1:0] lsu_addr,
    input  logic [XLEN-1:0]      lsu_data,
    input  logic                 issue_valid,
    input  logic [ADDR_SIZE-1:0] issue_addr,
    input  logic [ADDR_SIZE-1:0] query_addr1,
    input  logic [ADDR_SIZE-1:0] query_addr2,
    output logic                 busy1,
    output logic                 busy2,
    output logic                 write_enable,
    output logic [ADDR_SIZE-1:0] write_addr,
    output logic [XLEN-1:0]      write_data
`ifdef WB_FORWARD_EN
    ,
    output logic                 fwd1_valid,
    output logic                 fwd2_valid,
    output logic [XLEN-1:0]      fwd1_data,
    output logic [XLEN-1:0]      fwd2_data
`endif
);

    wb_req_t   w_alu_req;
    wb_req_t   w_lsu_req;
    wb_req_t   w_gnt_req;
    logic      w_alu_gnt;
    logic      w_lsu_gnt;
    logic      w_any_gnt;
    logic      w_raw_busy1;
    logic      w_raw_busy2;

    wb_src_e   r_ptr;
    logic      r_we;
    reg_addr_t r_waddr;
    logic [XLEN-1:0] r_wdata;

    assign w_alu_req = {alu_valid, alu_addr, alu_data};
    assign w_lsu_req = {lsu_valid, lsu_addr, lsu_data};

    // r_ptr names the requester that wins when both are valid.
    assign w_alu_gnt = rst && w_alu_req.valid && (!w_lsu_req.valid || r_ptr == WB_ALU);
    assign w_lsu_gnt = rst && w_lsu_req.valid && (!w_alu_req.valid || r_ptr == WB_LSU);
    assign w_any_gnt = w_alu_gnt || w_lsu_gnt;
    assign w_gnt_req = w_lsu_gnt ? w_lsu_req : w_alu_req;

    assign alu_ready = w_alu_gnt;
    assign lsu_ready = w_lsu_gnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr   <= WB_ALU;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_any_gnt && (w_gnt_req.addr != '0);
            if (w_any_gnt) begin
                r_waddr <= w_gnt_req.addr;
                r_wdata <= w_gnt_req.data;
                r_ptr   <= w_alu_gnt ? WB_LSU : WB_ALU;
            end
        end
    end

    assign write_enable = r_we;
    assign write_addr   = r_waddr;
    assign write_data   = r_wdata;

    regfile_scoreboard u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_set_valid   (issue_valid && (issue_addr != '0)),
        .i_set_addr    (issue_addr),
        .i_clr_valid   (r_we),
        .i_clr_addr    (r_waddr),
        .i_query_addr1 (query_addr1),
        .i_query_addr2 (query_addr2),
        .o_busy1       (w_raw_busy1),
        .o_busy2       (w_raw_busy2)
    );

`ifdef WB_FORWARD_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1 = r_we && (r_waddr == query_addr1) && (query_addr1 != '0);
    assign w_fwd2 = r_we && (r_waddr == query_addr2) && (query_addr2 != '0);

    // A same-cycle re-issue of the forwarded register keeps the consumer stalled.
    assign busy1 = w_raw_busy1 &&
                   !(w_fwd1 && !(issue_valid && issue_addr == query_addr1));
    assign busy2 = w_raw_busy2 &&
                   !(w_fwd2 && !(issue_valid && issue_addr == query_addr2));

    assign fwd1_valid = w_fwd1;
    assign fwd2_valid = w_fwd2;
    assign fwd1_data  = r_wdata;
    assign fwd2_data  = r_wdata;
`else
    assign busy1 = w_raw_busy1;
    assign busy2 = w_raw_busy2;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_arbiter
//  Description : Directed and random stimulus against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [4:0]  alu_addr = '0, lsu_addr = '0, issue_addr = '0;
    logic [4:0]  query_addr1 = '0, query_addr2 = '0;
    logic [31:0] alu_data = '0, lsu_data = '0;
    logic        alu_ready, lsu_ready, busy1, busy2, write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
`ifdef WB_FORWARD_EN
    logic        fwd1_valid, fwd2_valid;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: who was granted most recently, pending set, last write.
    bit        m_last_lsu;
    bit [31:0] m_pend;
    bit        m_we;
    bit [4:0]  m_wa;
    bit [31:0] m_wd;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_addr     (lsu_addr),
        .lsu_data     (lsu_data),
        .issue_valid  (issue_valid),
        .issue_addr   (issue_addr),
        .query_addr1  (query_addr1),
        .query_addr2  (query_addr2),
        .busy1        (busy1),
        .busy2        (busy2),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data)
`ifdef WB_FORWARD_EN
        ,
        .fwd1_valid   (fwd1_valid),
        .fwd2_valid   (fwd2_valid),
        .fwd1_data    (fwd1_data),
        .fwd2_data    (fwd2_data)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic bit model_busy(input bit [4:0] q, input bit iv, input bit [4:0] ia);
        bit b;
        b = (q != 0) && m_pend[q];
`ifdef WB_FORWARD_EN
        if (m_we && m_wa == q && q != 0 && !(iv && ia == q)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic cyc(input bit r,
                       input bit av, input bit [4:0] aa, input bit [31:0] ad,
                       input bit lv, input bit [4:0] la, input bit [31:0] ld,
                       input bit iv, input bit [4:0] ia,
                       input bit [4:0] q1, input bit [4:0] q2,
                       output bit ag, output bit lg);
        bit [31:0] np;
        @(negedge clk);
        rst = r;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        lsu_valid = lv; lsu_addr = la; lsu_data = ld;
        issue_valid = iv; issue_addr = ia;
        query_addr1 = q1; query_addr2 = q2;
        #1;
        // Grant rule: sole requester wins, otherwise the one not granted last.
        ag = r && av && (!lv || m_last_lsu);
        lg = r && lv && (!av || !m_last_lsu);
        check("alu_ready", alu_ready, ag);
        check("lsu_ready", lsu_ready, lg);
        check("busy1", busy1, model_busy(q1, iv, ia));
        check("busy2", busy2, model_busy(q2, iv, ia));
        check("write_enable", write_enable, m_we);
        if (m_we) begin
            check("write_addr", write_addr, m_wa);
            check("write_data", write_data, m_wd);
        end
`ifdef WB_FORWARD_EN
        check("fwd1_valid", fwd1_valid, m_we && m_wa == q1 && q1 != 0);
        check("fwd2_valid", fwd2_valid, m_we && m_wa == q2 && q2 != 0);
        if (m_we && m_wa == q2 && q2 != 0) check("fwd2_data", fwd2_data, m_wd);
`endif
        @(posedge clk);
        if (!r) begin
            m_last_lsu = 1'b1;
            m_pend = '0;
            m_we = 1'b0;
        end else begin
            np = m_pend;
            if (m_we) np[m_wa] = 1'b0;
            if (iv && ia != 0) np[ia] = 1'b1;
            m_pend = np;
            m_we = 1'b0;
            if (ag || lg) begin
                m_last_lsu = lg;
                m_wa = lg ? la : aa;
                m_wd = lg ? ld : ad;
                m_we = (m_wa != 0);
            end
        end
    endtask

    initial begin
        bit ag, lg;
        bit hav, hlv;
        bit [4:0] haa, hla;
        bit [31:0] had, hld;
        m_last_lsu = 1'b1; m_pend = '0; m_we = 1'b0; m_wa = '0; m_wd = '0;
        @(posedge clk);

        // Reset held with both requesters valid, then release into contention.
        repeat (2) cyc(0, 1, 3, 32'h11, 1, 4, 32'h22, 1, 3, 3, 4, ag, lg);
        repeat (4) cyc(1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 3, 4, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ag, lg);

        // Scoreboard set, then cleared by an LSU write.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, ag, lg);
        cyc(1, 0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, ag, lg);

        // Re-issue in the same cycle the write retires: bit stays set.
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5, 5, 0, ag, lg);
        cyc(1, 1, 5, 32'h55, 0, 0, 0, 0, 0, 5, 0, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 5, 5, 5, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, ag, lg);

        // Register x0: accepted but never written or tracked.
        cyc(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ag, lg);

        // Forwarding window on query port 2.
        cyc(1, 1, 9, 32'hABCD, 0, 0, 0, 1, 9, 0, 9, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, ag, lg);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, ag, lg);

        // Random traffic; requesters hold their request until accepted.
        hav = 0; hlv = 0; haa = 0; hla = 0; had = 0; hld = 0;
        for (int i = 0; i < 400; i++) begin
            bit r;
            r = ($urandom_range(0, 49) != 0);
            if (!hav && $urandom_range(0, 2) != 0) begin
                hav = 1; haa = 5'($urandom_range(0, 7)); had = $urandom;
            end
            if (!hlv && $urandom_range(0, 2) != 0) begin
                hlv = 1; hla = 5'($urandom_range(0, 7)); hld = $urandom;
            end
            cyc(r, hav, haa, had, hlv, hla, hld,
                bit'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ag, lg);
            if (ag) hav = 0;
            if (lg) hlv = 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
